goertzel_sample_rx: RTL and testbench

Sample front-end for the Goertzel bank in `FourierTransform`. It receives the differential `enable`/`sample` pins and checks that each pair is complementary. It frames exactly NS consecutive samples after software arms it, converts offset-binary samples to two's complement, and drives one registered sample stream to every Goertzel channel. Status and error flags feed the SPI STATUS register.

---
 rtl/goertzel_pkg.sv | 28 ++
 rtl/goertzel_sample_rx_diff_pair_rx.sv | 30 +++
 rtl/goertzel_sample_rx.sv | 182 ++++++++++++++++++
 tb/tb_goertzel_sample_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/goertzel_pkg.sv
// Shared definitions for the Goertzel block: receiver FSM states, STATUS
// register bit masks and the offset-binary to two's-complement helper.
package goertzel_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_ARMED = 2'd1,
        RX_RUN   = 2'd2,
        RX_DONE  = 2'd3
    } rx_state_t;

    // STATUS register bit masks
    localparam logic [31:0] STATUS_RESULT_RDY_MSK  = 32'h0000_0001;
    localparam logic [31:0] STATUS_OVF_MSK         = 32'h0000_0002;
    localparam logic [31:0] STATUS_RX_DONE_MSK     = 32'h0000_0004;
    localparam logic [31:0] STATUS_RX_PAIR_ERR_MSK = 32'h0000_0008;
    localparam logic [31:0] STATUS_RX_EN_ERR_MSK   = 32'h0000_0010;

    // Widest sample the helper below handles; callers zero-extend into it.
    localparam int unsigned OB_MAXW = 32;

    // Offset binary -> two's complement of a w-bit value: invert the MSB.
    function automatic logic [OB_MAXW-1:0] ob2tc(input logic [OB_MAXW-1:0] v,
                                                 input int unsigned       w);
        return v ^ (OB_MAXW'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/goertzel_sample_rx_diff_pair_rx.sv
// Registers one differential p/n bus. Data is the p leg; a bit is in error
// when both legs agree.
module diff_pair_rx #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] p,
    input  logic [W-1:0] n,
    output logic [W-1:0] data,
    output logic [W-1:0] err
);

    logic [W-1:0] p_q, n_q;

    // Single capture stage; pins are board-synchronous to clk.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            p_q <= '0;
            n_q <= '0;
        end else begin
            p_q <= p;
            n_q <= n;
        end
    end

    assign data = p_q;
    assign err  = p_q ~^ n_q;

endmodule

// File: rtl/goertzel_sample_rx.sv
// Sample front-end for the Goertzel bank: checks differential pin pairs,
// frames NS samples after arm, converts offset binary to two's complement and
// drives one registered stream plus sticky status. NS must be at least 2.
module goertzel_sample_rx
    import goertzel_pkg::*;
#(
    parameter int unsigned NS = 100000,
    parameter int unsigned SW = 8,
    parameter int unsigned CW = $clog2(NS + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable_p,
    input  logic          enable_n,
    input  logic [SW-1:0] sample_p,
    input  logic [SW-1:0] sample_n,
    input  logic          arm,
    input  logic          err_clr,
    output logic          out_valid,
    output logic [SW-1:0] out_sample,
    output logic          out_first,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          pair_err,
    output logic          en_err,
    output logic [CW-1:0] sample_cnt
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(NS);
    localparam logic [CW-1:0] CNT_LAST = CW'(NS - 1);

    // Input register stage
    logic          en_data, en_pair_bad;
    logic [SW-1:0] smp_data, smp_pair_bad;

    diff_pair_rx #(.W(1)) u_en_rx (
        .clk  (clk),
        .rstn (rstn),
        .p    (enable_p),
        .n    (enable_n),
        .data (en_data),
        .err  (en_pair_bad)
    );

    diff_pair_rx #(.W(SW)) u_smp_rx (
        .clk  (clk),
        .rstn (rstn),
        .p    (sample_p),
        .n    (sample_n),
        .data (smp_data),
        .err  (smp_pair_bad)
    );

    // A valid pair with p high means p=1, n=0.
    logic          en_ok, en_bad, bit_bad;
    logic [SW-1:0] s2c, fwd_sample;

    assign en_ok      = en_data & ~en_pair_bad;
    assign en_bad     = en_pair_bad;
    assign bit_bad    = |smp_pair_bad;
    assign s2c        = SW'(ob2tc(OB_MAXW'(smp_data), SW));
    // Broken pairs are replaced by mid-scale so the filters see no garbage.
    assign fwd_sample = bit_bad ? '0 : s2c;

    rx_state_t     state_q, state_d;
    logic          valid_q, valid_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic [SW-1:0] sample_q, sample_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pair_err_q, pair_err_d;
    logic          en_err_q, en_err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state and next-output decode of the framing FSM.
    always_comb begin
        logic fwd, set_en, set_pair;
        state_d  = state_q;
        valid_d  = 1'b0;
        first_d  = 1'b0;
        last_d   = 1'b0;
        sample_d = '0;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        fwd      = 1'b0;
        set_en   = 1'b0;
        set_pair = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (arm) begin
                    state_d = RX_ARMED;
                    cnt_d   = '0;
                end
            end
            RX_ARMED: begin
                if (en_ok) begin
                    fwd     = 1'b1;
                    first_d = 1'b1;
                    state_d = RX_RUN;
                end else if (en_bad) begin
                    set_en = 1'b1;
                end
            end
            RX_RUN: begin
                if (en_ok) begin
                    fwd = 1'b1;
                end else begin
                    // Truncated window: count is kept for software to read.
                    set_en  = 1'b1;
                    state_d = RX_IDLE;
                end
            end
            RX_DONE: begin
                // done rises one cycle after the last beat, as out_valid drops.
                if (arm) begin
                    state_d = RX_ARMED;
                    cnt_d   = '0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (fwd) begin
            valid_d  = 1'b1;
            sample_d = fwd_sample;
            set_pair = bit_bad;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
                last_d  = 1'b1;
                state_d = RX_DONE;
            end
        end

        busy_d     = (state_d == RX_ARMED) || (state_d == RX_RUN);
        // Sticky flags: a new error in the clear cycle wins.
        pair_err_d = set_pair | (pair_err_q & ~err_clr);
        en_err_d   = set_en | (en_err_q & ~err_clr);
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= RX_IDLE;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            sample_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pair_err_q <= 1'b0;
            en_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
            last_q     <= last_d;
            sample_q   <= sample_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pair_err_q <= pair_err_d;
            en_err_q   <= en_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_sample = sample_q;
    assign out_first  = first_q;
    assign out_last   = last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pair_err   = pair_err_q;
    assign en_err     = en_err_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_goertzel_sample_rx.sv
// Bench for goertzel_sample_rx: behavioural window model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_goertzel_sample_rx;

    localparam int NS = 4;
    localparam int SW = 8;
    localparam int CW = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          enable_p = 1'b0, enable_n = 1'b1;
    logic [SW-1:0] sample_p = '0, sample_n = '1;
    logic          arm = 1'b0, err_clr = 1'b0;
    logic          out_valid, out_first, out_last, busy, done, pair_err, en_err;
    logic [SW-1:0] out_sample;
    logic [CW-1:0] sample_cnt;

    always #5 clk = ~clk;

    goertzel_sample_rx #(.NS(NS), .SW(SW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable_p   (enable_p),
        .enable_n   (enable_n),
        .sample_p   (sample_p),
        .sample_n   (sample_n),
        .arm        (arm),
        .err_clr    (err_clr),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .out_first  (out_first),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .pair_err   (pair_err),
        .en_err     (en_err),
        .sample_cnt (sample_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ph: 0 idle, 1 waiting for enable, 2 inside window, 3 window finished
    int            ph = 0;
    int            m_cnt = 0;
    bit            m_valid, m_first, m_last, m_busy, m_done, m_perr, m_eerr;
    logic [SW-1:0] m_samp = '0;
    logic          pp_ep = 0, pp_en = 0;
    logic [SW-1:0] pp_sp = '0, pp_sn = '0;

    always @(posedge clk) begin
        if (!rstn) begin
            ph = 0; m_cnt = 0; m_samp = '0;
            {m_valid, m_first, m_last, m_busy, m_done, m_perr, m_eerr} = '0;
            pp_ep = 0; pp_en = 0; pp_sp = '0; pp_sn = '0;
        end else begin
            bit ok, bad, fwd, e_set, p_set;
            ok    = pp_ep && !pp_en;
            bad   = (pp_ep == pp_en);
            fwd   = 0; e_set = 0; p_set = 0;
            m_valid = 0; m_first = 0; m_last = 0; m_samp = '0;
            m_done  = (ph == 3) && !arm;
            case (ph)
                0, 3: if (arm) begin ph = 1; m_cnt = 0; end
                1: if (ok) begin fwd = 1; m_first = 1; ph = 2; end
                   else if (bad) e_set = 1;
                2: if (ok) fwd = 1; else begin e_set = 1; ph = 0; end
                default: ;
            endcase
            if (fwd) begin
                m_cnt++;
                m_valid = 1;
                if ((pp_sp ^ pp_sn) != {SW{1'b1}}) begin
                    p_set = 1;
                    m_samp = '0;
                end else begin
                    m_samp = SW'(int'(pp_sp) - (1 << (SW - 1)));
                end
                if (m_cnt == NS) begin m_last = 1; ph = 3; end
            end
            m_busy = (ph == 1) || (ph == 2);
            if (e_set) m_eerr = 1; else if (err_clr) m_eerr = 0;
            if (p_set) m_perr = 1; else if (err_clr) m_perr = 0;
            pp_ep = enable_p; pp_en = enable_n; pp_sp = sample_p; pp_sn = sample_n;
        end
    end

    // ---------------- compare + capture ----------------
    bit            run_cmp = 0;
    logic [SW-1:0] capq[$];
    int            last_seen = 0;
    int            first_seen = 0;

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("out_sample", out_sample, m_samp);
                chk("out_first", out_first, m_first);
                chk("out_last", out_last, m_last);
            end
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("pair_err", pair_err, m_perr);
            chk("en_err", en_err, m_eerr);
            chk("sample_cnt", sample_cnt, m_cnt);
            if (out_valid) begin
                capq.push_back(out_sample);
                if (out_first) first_seen++;
                if (out_last) last_seen++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic ep, input logic en, input logic [SW-1:0] sp,
                        input logic [SW-1:0] sn, input logic a, input logic c);
        enable_p = ep; enable_n = en; sample_p = sp; sample_n = sn;
        arm = a; err_clr = c;
        @(posedge clk); #1;
    endtask

    task automatic good(input logic [SW-1:0] s);
        step(1'b1, 1'b0, s, ~s, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic c = 1'b0);
        step(1'b0, 1'b1, '0, '1, 1'b0, c);
    endtask

    task automatic pulse_arm();
        step(1'b0, 1'b1, '0, '1, 1'b1, 1'b0);
    endtask

    task automatic clr_cap();
        capq.delete(); last_seen = 0; first_seen = 0;
    endtask

    initial begin
        logic [SW-1:0] rs, rn;
        logic          rep, ren;

        rstn = 1'b0;
        repeat (3) idle();
        rstn = 1'b1;
        run_cmp = 1;
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);

        // Window with mid/extreme codes
        clr_cap();
        pulse_arm();
        good(8'h80); good(8'hFF); good(8'h00); good(8'h81); good(8'h11); good(8'h22);
        idle(); idle(); idle();
        chk("t1_beats", capq.size(), 4);
        if (capq.size() == 4) begin
            chk("t1_b0", capq[0], 8'h00);
            chk("t1_b1", capq[1], 8'h7F);
            chk("t1_b2", capq[2], 8'h80);
            chk("t1_b3", capq[3], 8'h01);
        end
        chk("t1_first", first_seen, 1);
        chk("t1_last", last_seen, 1);
        chk("t1_done", done, 1);
        chk("t1_cnt", sample_cnt, 4);
        chk("t1_busy", busy, 0);
        chk("t1_mdl_cnt", m_cnt, 4);

        // Broken sample pair on beat 2
        clr_cap();
        pulse_arm();
        good(8'h10); step(1'b1, 1'b0, 8'h55, 8'h55, 1'b0, 1'b0); good(8'h20); good(8'h30);
        idle(); idle();
        chk("t2_beats", capq.size(), 4);
        if (capq.size() == 4) chk("t2_b1", capq[1], 8'h00);
        chk("t2_perr", pair_err, 1);
        chk("t2_cnt", sample_cnt, 4);
        idle(1'b1);
        chk("t2_perr_clr", pair_err, 0);

        // Enable drops after two beats
        clr_cap();
        pulse_arm();
        good(8'h01); good(8'h02); idle(); idle(); idle();
        chk("t3_eerr", en_err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_cnt", sample_cnt, 2);
        chk("t3_done", done, 0);
        chk("t3_last", last_seen, 0);
        chk("t3_beats", capq.size(), 2);

        // Invalid enable pair while armed, then a normal window
        idle(1'b1);
        clr_cap();
        pulse_arm();
        step(1'b1, 1'b1, 8'h40, 8'hBF, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h40, 8'hBF, 1'b0, 1'b0);
        idle();
        chk("t4_eerr", en_err, 1);
        chk("t4_novalid", capq.size(), 0);
        chk("t4_busy", busy, 1);
        good(8'hA0); good(8'hA1); good(8'hA2); good(8'hA3); idle(); idle();
        chk("t4_cnt", sample_cnt, 4);
        chk("t4_done", done, 1);
        chk("t4_beats", capq.size(), 4);

        // arm inside a window is ignored; arm in DONE re-arms
        idle(1'b1);
        clr_cap();
        pulse_arm();
        good(8'h11); good(8'h22); step(1'b1, 1'b0, 8'h33, 8'hCC, 1'b1, 1'b0);
        good(8'h44); good(8'h55); idle(); idle();
        chk("t5_beats", capq.size(), 4);
        chk("t5_last", last_seen, 1);
        chk("t5_done", done, 1);
        pulse_arm();
        chk("t5_rearm_done", done, 0);
        chk("t5_rearm_busy", busy, 1);
        chk("t5_rearm_cnt", sample_cnt, 0);
        good(8'h01); good(8'h02); good(8'h03); good(8'h04); idle(); idle();
        chk("t5_cnt2", sample_cnt, 4);

        // Reset in the middle of a window
        clr_cap();
        pulse_arm();
        good(8'h91); good(8'h92); good(8'h93);
        rstn = 1'b0;
        good(8'h94);
        chk("t6_valid", out_valid, 0);
        chk("t6_first", out_first, 0);
        chk("t6_lastp", out_last, 0);
        chk("t6_sample", out_sample, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_perr", pair_err, 0);
        chk("t6_eerr", en_err, 0);
        chk("t6_cnt", sample_cnt, 0);
        chk("t6_last", last_seen, 0);
        rstn = 1'b1;
        idle();
        clr_cap();
        pulse_arm();
        good(8'hC0); good(8'hC1); good(8'hC2); good(8'hC3); idle(); idle();
        chk("t6_cnt2", sample_cnt, 4);
        chk("t6_done2", done, 1);
        chk("t6_beats2", capq.size(), 4);

        // Random traffic against the model
        repeat (3000) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 80)      begin rep = 1'b1; ren = 1'b0; end
            else if (r < 90) begin rep = 1'b0; ren = 1'b1; end
            else             begin rep = 1'($urandom); ren = rep; end
            rs = SW'($urandom);
            rn = ~rs;
            if ($urandom_range(0, 15) == 0) rn = rn ^ SW'(1 << $urandom_range(0, SW - 1));
            rstn = ($urandom_range(0, 199) != 0);
            step(rep, ren, rs, rn, ($urandom_range(0, 11) == 0), ($urandom_range(0, 31) == 0));
        end
        rstn = 1'b1;
        idle(); idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
